// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux output among four requesters.
// A grant is held for a burst of up to max_burst beats under valid/ready.
module mux_rr_arbiter #(
  parameter int width     = 4,
  parameter int swidth    = 2,
  parameter int max_burst = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [width-1:0]  i0,
  input  logic [width-1:0]  i1,
  input  logic [width-1:0]  i2,
  input  logic [width-1:0]  i3,
  input  logic              o_ready,
  output logic [3:0]        gnt,
  output logic [swidth-1:0] sel,
  output logic [3:0]        ack,
  output logic [width-1:0]  o,
  output logic              o_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_n;
  logic [3:0]        gnt_n;
  logic [swidth-1:0] sel_n;
  logic [swidth-1:0] ptr, ptr_n;
  logic [3:0]        cnt, cnt_n;
  logic [swidth-1:0] pick, idx;
  logic [width-1:0]  mux;
  logic              found, busy, beat, last;

  assign busy    = (state == BUSY);
  assign o_valid = busy & req[sel];
  assign beat    = o_valid & o_ready;
  assign ack     = gnt & {4{beat}};
  assign last    = (cnt == 4'(max_burst - 1));
  assign o       = busy ? mux : '0;

  always_comb begin
    mux = '0;
    unique case (sel)
      2'd0: mux = i0;
      2'd1: mux = i1;
      2'd2: mux = i2;
      2'd3: mux = i3;
    endcase
  end

  // First active request scanning upward from ptr, wrapping mod 4.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < 4; j++) begin
      idx = ptr + swidth'(j);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          sel_n   = pick;
          gnt_n   = 4'b0001 << pick;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (!req[sel] || (beat && last)) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = sel + swidth'(1);
          cnt_n   = '0;
        end else if (beat) begin
          cnt_n = cnt + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  a_gnt_onehot0: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: beat scoreboard plus per-cycle grant checks.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i0, i1, i2, i3;
  logic       o_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] ack;
  logic [3:0] o;
  logic       o_valid;

  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] sel;
    logic [3:0] o;
  } beat_t;

  beat_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  mux_rr_arbiter #(.width(4), .swidth(2), .max_burst(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .o_ready(o_ready), .gnt(gnt), .sel(sel),
    .ack(ack), .o(o), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(int k, logic [3:0] d, int n);
    beat_t b;
    b.ack = 4'b0001 << k;
    b.sel = 2'(k);
    b.o   = d;
    repeat (n) sb.push_back(b);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample one cycle's grant; sel checked only while granted.
  task automatic tick(string tag, logic [3:0] eg);
    @(negedge clk);
    chk(tag, gnt, eg);
    for (int k = 0; k < 4; k++)
      if (eg == (4'b0001 << k)) chk({tag, "_sel"}, sel, k);
  endtask

  task automatic sb_done(string tag);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    cyc();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_beat", {28'd0, ack}, 0);
      end else begin
        e = sb.pop_front();
        chk("beat_ack", ack, e.ack);
        chk("beat_sel", sel, e.sel);
        chk("beat_o", o, e.o);
      end
    end
  end

  initial begin
    logic [3:0] g[$];
    logic [3:0] e;
    bit         pat[6];

    rst = 1'b1; req = '0; o_ready = 1'b0;
    i0 = 4'h5; i1 = 4'h6; i2 = 4'hA; i3 = 4'hC;
    #2;
    chk("rst_async_gnt", gnt, 0);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_o", o, 0);
    chk("rst_ack", ack, 0);
    cyc();
    rst = 1'b0;

    // single requester, burst, dead cycle, regrant, withdraw
    o_ready = 1'b1;
    req = 4'b0100;
    push(2, 4'hA, 4);
    g = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h0};
    for (int c = 0; c < 8; c++) begin
      if (c == 6) req = '0;
      tick("t1_gnt", g[c]);
      if (c == 1) chk("t1_ack", ack, 4'b0100);
      if (c == 5) chk("t1_gap_valid", o_valid, 0);
      if (c == 6) chk("t1_wd_valid", o_valid, 0);
      cyc();
    end
    sb_done("t1_sb");

    // all four requesting: 0,1,2,3,0 each 4 beats + 1 gap
    reset_dut();
    req = 4'b1111;
    o_ready = 1'b1;
    push(0, i0, 4); push(1, i1, 4); push(2, i2, 4);
    push(3, i3, 4); push(0, i0, 4);
    for (int c = 0; c < 26; c++) begin
      if (c == 25) req = '0;
      if (c == 0 || c % 5 == 0) e = 4'h0;
      else e = 4'b0001 << (((c - 1) / 5) % 4);
      tick("t2_gnt", e);
      cyc();
    end
    sb_done("t2_sb");

    // backpressure on requester 1
    reset_dut();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    req = 4'b0010;
    o_ready = 1'b0;
    push(1, i1, 4);
    for (int c = 0; c < 9; c++) begin
      if (c >= 1 && c <= 6) o_ready = pat[c-1];
      else o_ready = 1'b0;
      if (c == 7) req = '0;
      e = (c >= 1 && c <= 6) ? 4'b0010 : 4'b0000;
      tick("t3_gnt", e);
      chk("t3_ack", ack, (c >= 1 && c <= 6 && pat[c-1]) ? 4'b0010 : 4'b0);
      cyc();
    end
    sb_done("t3_sb");

    // early withdrawal of 3, then 0 gets the next grant
    reset_dut();
    o_ready = 1'b1;
    req = 4'b1000;
    push(3, i3, 2);
    push(0, i0, 4);
    g = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    for (int c = 0; c < 11; c++) begin
      if (c == 3) req = 4'b0001;
      if (c == 9) req = '0;
      tick("t4_gnt", g[c]);
      if (c == 3) chk("t4_wd_valid", o_valid, 0);
      cyc();
    end
    sb_done("t4_sb");

    // async reset during beat 2 of a grant to requester 1
    reset_dut();
    o_ready = 1'b1;
    req = 4'b0010;
    push(1, i1, 1);
    tick("t5_gnt", 4'h0);
    cyc();
    tick("t5_gnt", 4'h2);
    cyc();
    chk("t5_pre_valid", o_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_gnt", gnt, 0);
    chk("t5_async_valid", o_valid, 0);
    chk("t5_async_ack", ack, 0);
    chk("t5_async_sel", sel, 0);
    sb_done("t5_sb_abandon");
    cyc();
    rst = 1'b0;
    push(1, i1, 4);
    g = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    for (int c = 0; c < 6; c++) begin
      if (c == 5) req = '0;
      tick("t5_gnt", g[c]);
      cyc();
    end
    sb_done("t5_sb");

    // priority rotation: 0, then 3 ahead of 0, then 0
    reset_dut();
    o_ready = 1'b1;
    req = 4'b0001;
    push(0, i0, 4); push(3, i3, 4); push(0, i0, 4);
    g = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8,
          4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    for (int c = 0; c < 17; c++) begin
      if (c == 5) req = 4'b1001;
      if (c == 15) req = '0;
      tick("t6_gnt", g[c]);
      cyc();
    end
    sb_done("t6_sb");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one width-bit 4:1 multiplexer output channel among four requesters.
- Grants one requester at a time, drives the mux select, and holds the grant for a burst of beats under a valid/ready handshake.
- Rotates priority after each grant ends.
- Sits between four data sources and a single downstream consumer.

Parameters:
- width, 4, data width of each requester input and of the output.
- swidth, 2, select width; fixed at 2 (four requesters).
- max_burst, 4, maximum beats per grant before forced release; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  per-requester request; bit k is held high while requester k has data.
- i0  input  width  requester 0 data.
- i1  input  width  requester 1 data.
- i2  input  width  requester 2 data.
- i3  input  width  requester 3 data.
- o_ready  input  1  downstream accepts a beat this cycle.
- gnt  output  4  one-hot registered grant; all zero when idle.
- sel  output  swidth  registered index of the granted requester.
- ack  output  4  per-requester beat-accepted strobe: gnt & {4{o_valid & o_ready}}.
- o  output  width  muxed data; i[sel] while BUSY, else 0.
- o_valid  output  1  BUSY & req[sel].

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-burst):
  - state=IDLE, gnt=0, sel=0, ptr=0, cnt=0.
  - Consequently o_valid=0, o=0, ack=0.
  - Any in-flight burst is abandoned; no ack is produced.
- State IDLE:
  - If req==0: stay IDLE.
  - Otherwise, choose the first k with req[k]=1, scanning ptr, ptr+1, ... modulo 4.
  - Next edge: sel=k, gnt=one-hot(k), cnt=0, state=BUSY.
  - Arbitration latency: req rising to gnt asserted is 1 clock.
- State BUSY:
  - o = i[sel] combinationally; o_valid = req[sel].
  - A beat transfers on an edge where o_valid && o_ready. On that edge cnt increments and ack[sel] is high during that cycle.
  - Release on the edge where either:
    - req[sel]=0 (requester withdrew), or
    - a beat transfers with cnt==max_burst-1.
  - On release: state=IDLE, gnt=0, sel unchanged, ptr=(sel+1) mod 4, cnt=0.
  - Exactly one dead IDLE cycle follows each release, before the next grant.
  - o_ready low stalls: no beat, cnt holds, grant holds indefinitely while req[sel]=1.
  - Requests from other requesters during BUSY are ignored until release. No preemption.
- Simultaneous events:
  - If req[sel] drops in the same cycle o_ready is high, o_valid=0, so no beat transfers; release occurs.
  - If the final beat transfers while req[sel] stays high, release still occurs. The requester re-competes at lowest priority.
- Fairness:
  - With all four requesting continuously, grant order is 0,1,2,3,0,... each for max_burst beats.
  - No requester waits more than 3 grants.
- Counter: cnt is 4 bits, never exceeds max_burst-1, no wrap.
- Invariant: gnt is one-hot or zero at all times. Assertion required.

Test Plan:
- Reset then single requester: req=4'b0100, o_ready=1, i2=4'hA, max_burst=4.
  - gnt=4'b0100 and sel=2 one cycle after req.
  - 4 beats with o=4'hA, ack[2] high 4 cycles.
  - gnt=0 for 1 cycle, then re-grant to 2.
- All requesting: req=4'b1111, o_ready=1 constant.
  - sel sequence 0,1,2,3,0 with 4 beats each and 1 idle cycle between grants.
  - Each grant lasts 5 cycles including the gap.
- Backpressure: grant to 1, o_ready toggles 1,0,0,1,1,1.
  - Exactly 4 acks occur, on the o_ready=1 cycles.
  - cnt holds during stalls; release after the 4th beat.
- Early withdrawal: grant to 3, req[3] drops after 2 beats while req[0]=1.
  - Release with 2 acks.
  - Next grant goes to 0 (ptr=0), after 1 idle cycle.
- Async reset mid-burst: assert rst between edges during beat 2 of a grant to requester 1.
  - gnt, o_valid, ack go to 0 immediately without waiting for clk.
  - After rst deasserts with req=4'b0010, the next grant is 1 (ptr=0 scan finds 1).
- Priority rotation: grant to 0 completes; then req=4'b1001.
  - Next grant is 3, not 0.
  - After 3 completes, ptr=0, and with req=4'b1001 the next grant is 0.
